sd_nibble_packer: RTL and testbench

//  Downstream of the SD read controller. Consumes the 4-bit DAT nibble stream (valid/last) and packs it

---
 rtl/sd_nibble_packer_if.sv | 28 ++
 rtl/sd_nibble_packer.sv | 138 +++++++++++++
 tb/tb_sd_nibble_packer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sd_nibble_packer_if.sv
// sd_nibble_packer_if: nibble-stream input, word-stream output and status
// signals of the SD nibble packer, bundled with master/slave views.
interface sd_nibble_packer_if #(
  parameter int g_WORD_WIDTH = 64
);
  logic                    i_DATA_VALID;
  logic [3:0]              i_DATA_NIBBLE;
  logic                    i_LAST_NIBBLE;
  logic                    i_FLUSH;
  logic [g_WORD_WIDTH-1:0] o_WORD;
  logic                    o_WORD_VALID;
  logic                    i_WORD_READY;
  logic                    o_WORD_LAST;
  logic                    o_BLOCK_DONE;
  logic                    o_OVERFLOW;

  // Driver side: SD controller plus core consumer.
  modport master (
    output i_DATA_VALID, i_DATA_NIBBLE, i_LAST_NIBBLE, i_FLUSH, i_WORD_READY,
    input  o_WORD, o_WORD_VALID, o_WORD_LAST, o_BLOCK_DONE, o_OVERFLOW
  );

  // Packer side.
  modport slave (
    input  i_DATA_VALID, i_DATA_NIBBLE, i_LAST_NIBBLE, i_FLUSH, i_WORD_READY,
    output o_WORD, o_WORD_VALID, o_WORD_LAST, o_BLOCK_DONE, o_OVERFLOW
  );
endinterface

// File: rtl/sd_nibble_packer.sv
// sd_nibble_packer: packs the SD 4-bit DAT stream into g_WORD_WIDTH-bit
// little-endian words, buffers them in a small FIFO and offers them to the
// core over valid/ready. The SD side cannot stall, so a word completing
// into a full FIFO (with no pop that cycle) is dropped and o_OVERFLOW sticks.
// Optional build macro: SDC_PACKER_ENDIAN_SWAP_EN byte-reverses o_WORD at
// the FIFO output (byte 0 lands in the MSB byte).
module sd_nibble_packer #(
  parameter int g_WORD_WIDTH = 64,
  parameter int g_FIFO_DEPTH = 4
) (
  input logic               CLK,
  input logic               a_RST_N,
  sd_nibble_packer_if.slave bus
);

  localparam int NIB_PER_WORD = g_WORD_WIDTH / 4;
  localparam int CNT_W        = $clog2(NIB_PER_WORD);
  localparam int PTR_W        = $clog2(g_FIFO_DEPTH);
  localparam int POS_W        = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB_PER_WORD - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [g_WORD_WIDTH-1:0] part_q, part_d;
  logic [PTR_W:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]          rd_ptr_q, rd_ptr_d;
  logic                    done_q, done_d;
  logic                    ovf_q, ovf_d;

  logic [g_WORD_WIDTH-1:0] mem_q [g_FIFO_DEPTH];
  logic                    last_mem_q [g_FIFO_DEPTH];

  logic                    nib_in;
  logic                    word_done;
  logic [POS_W-1:0]        nib_pos;
  logic [g_WORD_WIDTH-1:0] word_asm;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    pop;
  logic                    push;
  logic [g_WORD_WIDTH-1:0] head_word;

  // Reverses byte order; padding bytes of a short word end up at the low end.
  function automatic logic [g_WORD_WIDTH-1:0] byte_swap(input logic [g_WORD_WIDTH-1:0] w);
    logic [g_WORD_WIDTH-1:0] r;
    r = '0;
    for (int b = 0; b < g_WORD_WIDTH / 8; b++) begin
      r[8*b +: 8] = w[g_WORD_WIDTH - 8 - 8*b +: 8];
    end
    return r;
  endfunction

  // Nibble placement, word completion and FIFO push/pop decisions.
  always_comb begin
    nib_in     = bus.i_DATA_VALID & ~bus.i_FLUSH;
    // Even count -> high nibble of the byte, odd count -> low nibble.
    nib_pos    = {cnt_q ^ CNT_W'(1), 2'b00};
    word_asm   = part_q | (g_WORD_WIDTH'(bus.i_DATA_NIBBLE) << nib_pos);
    word_done  = nib_in & ((cnt_q == CNT_LAST) | bus.i_LAST_NIBBLE);
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    pop        = ~fifo_empty & bus.i_WORD_READY;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push       = word_done & (~fifo_full | pop);
  end

  // Next-state for packer and FIFO control; flush overrides everything.
  always_comb begin
    cnt_d    = cnt_q;
    part_d   = part_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    if (bus.i_FLUSH) begin
      cnt_d    = '0;
      part_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end else begin
      if (nib_in) begin
        if (word_done) begin
          // Partial word is cleared so the next block's short word pads with zeros.
          cnt_d  = '0;
          part_d = '0;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          part_d = word_asm;
        end
      end
      if (push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
      done_d = word_done & bus.i_LAST_NIBBLE;
      if (word_done && !push) ovf_d = 1'b1;
    end
  end

  // Control and partial-word state, async active-low reset.
  always_ff @(posedge CLK or negedge a_RST_N) begin
    if (!a_RST_N) begin
      cnt_q    <= '0;
      part_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      part_q   <= part_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents only matter behind valid pointers, so no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]]      <= word_asm;
      last_mem_q[wr_ptr_q[PTR_W-1:0]] <= bus.i_LAST_NIBBLE;
    end
  end

  assign head_word = mem_q[rd_ptr_q[PTR_W-1:0]];

`ifdef SDC_PACKER_ENDIAN_SWAP_EN
  assign bus.o_WORD = fifo_empty ? '0 : byte_swap(head_word);
`else
  assign bus.o_WORD = fifo_empty ? '0 : head_word;
`endif
  assign bus.o_WORD_VALID = ~fifo_empty;
  assign bus.o_WORD_LAST  = ~fifo_empty & last_mem_q[rd_ptr_q[PTR_W-1:0]];
  assign bus.o_BLOCK_DONE = done_q;
  assign bus.o_OVERFLOW   = ovf_q;

endmodule

// File: tb/tb_sd_nibble_packer.sv
// tb_sd_nibble_packer: scoreboard bench for sd_nibble_packer (64-bit words,
// 4-deep FIFO). Directed scenarios plus randomized traffic; a reference
// model builds expected words from collected nibbles and queues them, and a
// negedge monitor compares the DUT head against the queue.
module tb_sd_nibble_packer;
  localparam int W     = 64;
  localparam int DEPTH = 4;
  localparam int NIB   = W / 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sd_nibble_packer_if #(.g_WORD_WIDTH(W)) bus ();

  sd_nibble_packer #(.g_WORD_WIDTH(W), .g_FIFO_DEPTH(DEPTH)) dut (
    .CLK     (clk),
    .a_RST_N (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state (as of the most recent clock edge).
  logic [W:0] exp_q[$];      // {last, word} expected at the DUT head, in order
  logic [3:0] nibs[$];       // nibbles of the word under construction
  int         occ_m = 0;
  bit         ovf_m = 1'b0;
  bit         done_m = 1'b0;
  int         pops_seen = 0;
  int         last_seen = 0;
  int         done_seen = 0;

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Byte b = {nibble 2b, nibble 2b+1}; missing nibbles are zero padding.
  function automatic logic [W-1:0] build_word();
    logic [W-1:0] w;
    logic [3:0] hi, lo;
    w = '0;
    for (int b = 0; b < W / 8; b++) begin
      hi = (2*b   < nibs.size()) ? nibs[2*b]   : 4'h0;
      lo = (2*b+1 < nibs.size()) ? nibs[2*b+1] : 4'h0;
      w[8*b +: 8] = {hi, lo};
    end
`ifdef SDC_PACKER_ENDIAN_SWAP_EN
    begin
      logic [W-1:0] r;
      for (int b = 0; b < W / 8; b++) r[8*b +: 8] = w[W - 8 - 8*b +: 8];
      w = r;
    end
`endif
    return w;
  endfunction

  // One clock cycle: drive inputs, take the edge, advance the model.
  task automatic step(input logic v, input logic [3:0] n, input logic l,
                      input logic rdy, input logic fl);
    bit pop;
    logic [W-1:0] w;
    bus.i_DATA_VALID  = v;
    bus.i_DATA_NIBBLE = n;
    bus.i_LAST_NIBBLE = l;
    bus.i_WORD_READY  = rdy;
    bus.i_FLUSH       = fl;
    @(posedge clk);
    if (fl) begin
      occ_m = 0; ovf_m = 1'b0; done_m = 1'b0;
      nibs.delete(); exp_q.delete();
    end else begin
      pop = (occ_m > 0) && rdy;
      done_m = 1'b0;
      if (v) begin
        nibs.push_back(n);
        if (nibs.size() == NIB || l) begin
          w = build_word();
          if (occ_m < DEPTH || pop) begin
            exp_q.push_back({l, w});
            occ_m++;
          end else begin
            ovf_m = 1'b1;
          end
          if (l) done_m = 1'b1;
          nibs.delete();
        end
      end
      if (pop) occ_m--;
    end
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, rdy, 1'b0);
  endtask

  task automatic send_words(input int nwords, input logic rdy);
    for (int i = 0; i < nwords * NIB; i++) step(1'b1, 4'($urandom), 1'b0, rdy, 1'b0);
  endtask

  // Async reset taken between edges; outputs must clear without a clock.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_valid",    {64'h0, bus.o_WORD_VALID}, '0);
    chk("rst_word",     {1'b0, bus.o_WORD},        '0);
    chk("rst_last",     {64'h0, bus.o_WORD_LAST},  '0);
    chk("rst_done",     {64'h0, bus.o_BLOCK_DONE}, '0);
    chk("rst_overflow", {64'h0, bus.o_OVERFLOW},   '0);
    occ_m = 0; ovf_m = 1'b0; done_m = 1'b0;
    nibs.delete(); exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compare head/status to the model away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid",      {64'h0, bus.o_WORD_VALID}, {64'h0, occ_m > 0});
      chk("overflow",   {64'h0, bus.o_OVERFLOW},   {64'h0, ovf_m});
      chk("block_done", {64'h0, bus.o_BLOCK_DONE}, {64'h0, done_m});
      if (bus.o_BLOCK_DONE) done_seen++;
      if (bus.o_WORD_VALID) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL head_word actual=%h required=<none queued>", bus.o_WORD);
        end else begin
          chk("head_word", {bus.o_WORD_LAST, bus.o_WORD}, exp_q[0]);
          if (bus.i_WORD_READY) begin
            if (exp_q[0][W]) last_seen++;
            void'(exp_q.pop_front());
            pops_seen++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, l0, d0;
    logic [W-1:0] t4_word;
    bus.i_DATA_VALID = 1'b0; bus.i_DATA_NIBBLE = 4'h0; bus.i_LAST_NIBBLE = 1'b0;
    bus.i_WORD_READY = 1'b0; bus.i_FLUSH = 1'b0;
    async_reset();
    idle(2, 1'b1);

    // Test 1: nibbles 1..F,0 back-to-back, ready high.
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i + 1), 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Test 2: full 512-byte block.
    p0 = pops_seen; l0 = last_seen; d0 = done_seen;
    for (int i = 0; i < 1024; i++) step(1'b1, 4'($urandom), i == 1023, 1'b1, 1'b0);
    idle(4, 1'b1);
    chk("t2_words", 65'(pops_seen - p0), 65'd64);
    chk("t2_last",  65'(last_seen - l0), 65'd1);
    chk("t2_done",  65'(done_seen - d0), 65'd1);
    chk("t2_ovf",   {64'h0, bus.o_OVERFLOW}, '0);

    // Test 3: five words into a stalled 4-deep FIFO, then drain.
    send_words(5, 1'b0);
    idle(1, 1'b0);
    chk("t3_ovf", {64'h0, bus.o_OVERFLOW}, 65'd1);
    p0 = pops_seen;
    idle(6, 1'b1);
    chk("t3_drained", 65'(pops_seen - p0), 65'd4);

    // Test 4: short block A..F padded, then the next block starts at byte 0.
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 4'(4'hA + i), i == 5, 1'b0, 1'b0);
`ifdef SDC_PACKER_ENDIAN_SWAP_EN
    t4_word = 64'hABCD_EF00_0000_0000;
`else
    t4_word = 64'h0000_0000_00EF_CDAB;
`endif
    chk("t4_word", {bus.o_WORD_LAST, bus.o_WORD}, {1'b1, t4_word});
    idle(2, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i + 1), 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Test 5: word completes into a full FIFO while a pop happens; then flush.
    send_words(4, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b1, 4'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'($urandom), 1'b0, 1'b1, 1'b0);
    chk("t5_no_ovf", {64'h0, bus.o_OVERFLOW}, '0);
    chk("t5_occ",    {64'h0, bus.o_WORD_VALID}, 65'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 4'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'($urandom), 1'b0, 1'b0, 1'b1);
    chk("t5_flush_valid", {64'h0, bus.o_WORD_VALID}, '0);
    chk("t5_flush_ovf",   {64'h0, bus.o_OVERFLOW},   '0);
    send_words(1, 1'b1);
    idle(3, 1'b1);

    // Test 6: async reset mid-word and mid-FIFO, then a fresh word.
    send_words(2, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 4'($urandom), 1'b0, 1'b0, 1'b0);
    async_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i + 1), 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Randomized traffic: bursts, stalls, short blocks, occasional flush.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 9) < 7, 4'($urandom), $urandom_range(0, 59) == 0,
           $urandom_range(0, 9) < 5, $urandom_range(0, 299) == 0);
    end
    idle(10, 1'b1);
    chk("final_drained", 65'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
